muldiv_sequencer: RTL and testbench

//  Multi-cycle signed multiply/divide unit with its own sequencer. It replaces the single-cycle mul/div path.
//  The control unit issues a request from mul/div states (operands from the Y register and the bus) and stalls on busy.
//  On done it writes the result to HI and LO. One operation in flight at a time.
//  The datapath is shift-add (mul) / restoring shift-subtract (div) on magnitudes, with a sign fix-up at the end.

---
 rtl/muldiv_pkg.sv | 18 +
 rtl/muldiv_if.sv | 29 ++
 rtl/muldiv_step.sv | 42 ++++
 rtl/muldiv_sequencer.sv | 117 +++++++++++
 tb/tb_muldiv_sequencer.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the multi-cycle signed multiply/divide unit:
// sequencer state encoding, operation codes and default sizing.
package muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  localparam int          DEF_WIDTH       = 32;
  localparam logic [31:0] DEF_DZ_QUOTIENT = 32'hFFFF_FFFF;

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between the control unit (master) and the
// multiply/divide sequencer (slave).
interface muldiv_if
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             dz;

  modport master (
    output start, op, a, b,
    input  busy, done, hi, lo, dz
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, hi, lo, dz
  );

endinterface

// File: rtl/muldiv_step.sv
// One iteration of the magnitude datapath: shift-add for MUL, restoring
// shift-subtract for DIV, operating on the {acc, q} register pair.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             op,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             fits;

  // The partial remainder is always below m, so the successful difference
  // fits in WIDTH bits even though the shifted value needs WIDTH+1.
  always_comb begin
    sum      = {1'b0, acc} + (q[0] ? {1'b0, m} : '0);
    shifted  = {acc, q[WIDTH-1]};
    fits     = (shifted >= {1'b0, m});
    diff     = shifted[WIDTH-1:0] - m;
    acc_next = acc;
    q_next   = q;
    if (op == OP_MUL) begin
      acc_next = sum[WIDTH:1];
      q_next   = {sum[0], q[WIDTH-1:1]};
    end else if (fits) begin
      acc_next = diff;
      q_next   = {q[WIDTH-2:0], 1'b1};
    end else begin
      acc_next = shifted[WIDTH-1:0];
      q_next   = {q[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle signed multiply/divide: runs WIDTH magnitude iterations, then
// applies the sign fix-up and presents HI/LO with a one-cycle done pulse.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int               WIDTH       = DEF_WIDTH,
  parameter int               CNT_W       = 6,
  parameter logic [WIDTH-1:0] DZ_QUOTIENT = WIDTH'(DEF_DZ_QUOTIENT)
) (
  input logic     Clock,
  input logic     Reset,
  muldiv_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t             state, next_state;
  logic [CNT_W-1:0]   cnt;
  logic               op_r, sign_a, sign_b;
  logic [WIDTH-1:0]   acc, q, m;
  logic [WIDTH-1:0]   acc_next, q_next;
  logic [WIDTH-1:0]   hi_r, lo_r, hi_fix, lo_fix;
  logic [2*WIDTH-1:0] prod;
  logic               dz_r, div_by_zero;

  assign div_by_zero = (bus.op == OP_DIV) && (bus.b == '0);

  always_ff @(posedge Clock) begin
    if (Reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (bus.start) next_state = div_by_zero ? DONE : ITER;
      ITER: if (cnt == LAST_ITER) next_state = FIX;
      FIX:  next_state = DONE;
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .op       (op_r),
    .acc      (acc),
    .q        (q),
    .m        (m),
    .acc_next (acc_next),
    .q_next   (q_next)
  );

  // Remainder follows the dividend's sign; product and quotient are negated
  // when the operand signs differ.
  always_comb begin
    prod   = {acc, q};
    hi_fix = acc;
    lo_fix = q;
    if (op_r == OP_MUL) begin
      if (sign_a ^ sign_b) prod = -prod;
      hi_fix = prod[2*WIDTH-1:WIDTH];
      lo_fix = prod[WIDTH-1:0];
    end else begin
      if (sign_a)          hi_fix = -acc;
      if (sign_a ^ sign_b) lo_fix = -q;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      cnt    <= '0;
      op_r   <= OP_MUL;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      acc    <= '0;
      q      <= '0;
      m      <= '0;
      hi_r   <= '0;
      lo_r   <= '0;
      dz_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          op_r   <= bus.op;
          sign_a <= bus.a[WIDTH-1];
          sign_b <= bus.b[WIDTH-1];
          acc    <= '0;
          q      <= bus.a[WIDTH-1] ? -bus.a : bus.a;
          m      <= bus.b[WIDTH-1] ? -bus.b : bus.b;
          cnt    <= '0;
          dz_r   <= div_by_zero;
          if (div_by_zero) begin
            hi_r <= bus.a;
            lo_r <= DZ_QUOTIENT;
          end
        end
        ITER: begin
          acc <= acc_next;
          q   <= q_next;
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          hi_r <= hi_fix;
          lo_r <= lo_fix;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state == ITER) || (state == FIX);
  assign bus.done = (state == DONE);
  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;
  assign bus.dz   = dz_r;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: a table of signed MUL/DIV vectors with
// hand-computed results, plus sequences for ignored restart and mid-op reset.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic        exp_dz;
    int          exp_lat;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;

  int checks   = 0;
  int failures = 0;

  logic [31:0] r_hi, r_lo;
  logic        r_dz, r_done_after;
  int          r_lat, r_busy;

  muldiv_if #(.WIDTH(32)) bus ();

  muldiv_sequencer #(.WIDTH(32), .CNT_W(6), .DZ_QUOTIENT(32'hFFFF_FFFF)) dut (
    .Clock (clock),
    .Reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // Waits for done from a point n0 cycles after the accept edge.
  task automatic waitDone(input int n0);
    int n;
    n      = n0;
    r_busy = 0;
    while (!bus.done && n < 100) begin
      if (bus.busy) r_busy++;
      step();
      n++;
    end
    r_lat = n;
    r_hi  = bus.hi;
    r_lo  = bus.lo;
    r_dz  = bus.dz;
    step();
    r_done_after = bus.done;
  endtask

  task automatic applyStimulus(input logic op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    step();
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
    waitDone(0);
  endtask

  vec_t vecs[12];
  int   pulses;

  initial begin
    vecs[0]  = '{OP_MUL, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 33};
    vecs[1]  = '{OP_MUL, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 33};
    vecs[2]  = '{OP_MUL, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 1'b0, 33};
    vecs[3]  = '{OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33};
    vecs[4]  = '{OP_DIV, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 33};
    vecs[5]  = '{OP_DIV, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF, 1'b1, 0};
    vecs[6]  = '{OP_MUL, 32'h0000_0002, 32'h0000_0003, 32'h0000_0000, 32'h0000_0006, 1'b0, 33};
    vecs[7]  = '{OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 33};
    vecs[8]  = '{OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0, 33};
    vecs[9]  = '{OP_DIV, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 1'b0, 33};
    vecs[10] = '{OP_DIV, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'h0000_000E, 1'b0, 33};
    vecs[11] = '{OP_MUL, 32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 33};

    bus.start = 1'b0;
    bus.op    = OP_MUL;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) step();
    reset = 1'b0;
    step();

    checkOutput("reset_busy", 64'(bus.busy), 64'd0);
    checkOutput("reset_done", 64'(bus.done), 64'd0);
    checkOutput("reset_hi",   64'(bus.hi),   64'd0);
    checkOutput("reset_lo",   64'(bus.lo),   64'd0);
    checkOutput("reset_dz",   64'(bus.dz),   64'd0);

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b);
      checkOutput($sformatf("v%0d_hi", i),        64'(r_hi),         64'(vecs[i].exp_hi));
      checkOutput($sformatf("v%0d_lo", i),        64'(r_lo),         64'(vecs[i].exp_lo));
      checkOutput($sformatf("v%0d_dz", i),        64'(r_dz),         64'(vecs[i].exp_dz));
      checkOutput($sformatf("v%0d_latency", i),   64'(r_lat),        64'(vecs[i].exp_lat));
      checkOutput($sformatf("v%0d_busy_cyc", i),  64'(r_busy),       64'(vecs[i].exp_lat));
      checkOutput($sformatf("v%0d_done_1cyc", i), 64'(r_done_after), 64'd0);
    end

    // A second start ten cycles into a MUL must not disturb or queue anything.
    bus.start = 1'b1;
    bus.op    = OP_MUL;
    bus.a     = 32'd3;
    bus.b     = 32'd4;
    step();
    bus.start = 1'b0;
    repeat (9) step();
    bus.start = 1'b1;
    bus.a     = 32'd9;
    bus.b     = 32'd9;
    step();
    bus.start = 1'b0;
    waitDone(10);
    checkOutput("restart_latency", 64'(r_lat),        64'd33);
    checkOutput("restart_hi",      64'(r_hi),         64'd0);
    checkOutput("restart_lo",      64'(r_lo),         64'h0000_000C);
    checkOutput("restart_done1",   64'(r_done_after), 64'd0);
    pulses = 0;
    repeat (40) begin
      if (bus.done) pulses++;
      step();
    end
    checkOutput("restart_no_extra_done", 64'(pulses), 64'd0);

    // Reset twenty cycles into a DIV aborts it cleanly.
    bus.start = 1'b1;
    bus.op    = OP_DIV;
    bus.a     = 32'd100;
    bus.b     = 32'd7;
    step();
    bus.start = 1'b0;
    repeat (19) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checkOutput("abort_busy", 64'(bus.busy), 64'd0);
    checkOutput("abort_done", 64'(bus.done), 64'd0);
    checkOutput("abort_hi",   64'(bus.hi),   64'd0);
    checkOutput("abort_lo",   64'(bus.lo),   64'd0);
    pulses = 0;
    repeat (40) begin
      if (bus.done) pulses++;
      step();
    end
    checkOutput("abort_no_done", 64'(pulses), 64'd0);

    applyStimulus(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    checkOutput("post_abort_lo",      64'(r_lo),  64'h8000_0000);
    checkOutput("post_abort_hi",      64'(r_hi),  64'd0);
    checkOutput("post_abort_latency", 64'(r_lat), 64'd33);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
